// File: rtl/instr_encoder_loader.sv
// Packs field-level MIPS instruction requests into 32-bit words and streams them
// into instruction memory from BASE_ADDR upward, one acknowledged write at a time.
module instr_encoder_loader #(
  parameter int ADDR_W    = 12,
  parameter int BASE_ADDR = 0,
  parameter int DEPTH     = 256,
  localparam int CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic              enc_valid_i,
  output logic              enc_ready_o,
  input  logic [1:0]        enc_fmt_i,
  input  logic [5:0]        enc_op_i,
  input  logic [5:0]        enc_funct_i,
  input  logic [4:0]        enc_rs_i,
  input  logic [4:0]        enc_rt_i,
  input  logic [4:0]        enc_rd_i,
  input  logic [4:0]        enc_shamt_i,
  input  logic [15:0]       enc_imm_i,
  input  logic [25:0]       enc_target_i,
  output logic              imem_wr_en_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wr_data_o,
  input  logic              imem_ack_i,
  output logic [CNT_W-1:0]  count_o,
  output logic              full_o,
  output logic              done_o,
  output logic              err_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCEPT = 2'd1,
    S_WRITE  = 2'd2,
    S_FULL   = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [CNT_W-1:0]  LAST = CNT_W'(DEPTH - 1);

  // J-format only carries jumps; I-format must not alias R-type or jump opcodes.
  function automatic logic is_legal(input logic [1:0] fmt, input logic [5:0] op);
    logic ok;
    case (fmt)
      2'd0:    ok = 1'b1;
      2'd1:    ok = (op != 6'h00) && (op != 6'h02) && (op != 6'h03);
      2'd2:    ok = (op == 6'h02) || (op == 6'h03);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [31:0] encode(
    input logic [1:0]  fmt,
    input logic [5:0]  op,
    input logic [5:0]  funct,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [4:0]  shamt,
    input logic [15:0] imm,
    input logic [25:0] target
  );
    logic [31:0] word;
    case (fmt)
      2'd0:    word = {6'h00, rs, rt, rd, shamt, funct};
      2'd1:    word = {op, rs, rt, imm};
      2'd2:    word = {op, target};
      default: word = 32'h0000_0000;
    endcase
    return word;
  endfunction

  state_t             state_r;
  state_t             next_s;
  logic               latch_s;
  logic               drop_s;
  logic               step_s;
  logic               done_s;
  logic               reinit_s;
  logic               ready_r;
  logic               wr_en_r;
  logic               full_r;
  logic               done_r;
  logic               err_r;
  logic [ADDR_W-1:0]  addr_r;
  logic [CNT_W-1:0]   count_r;
  logic [31:0]        wr_data_r;

  // Next-state and per-cycle action decode; start_i overrides every state.
  always_comb begin
    next_s   = state_r;
    latch_s  = 1'b0;
    drop_s   = 1'b0;
    step_s   = 1'b0;
    done_s   = 1'b0;
    reinit_s = 1'b0;
    if (start_i) begin
      next_s   = S_ACCEPT;
      reinit_s = 1'b1;
    end else begin
      case (state_r)
        S_IDLE: next_s = S_IDLE;
        S_ACCEPT: begin
          if (stop_i) begin
            next_s = S_IDLE;
            done_s = 1'b1;
          end else if (enc_valid_i) begin
            if (is_legal(enc_fmt_i, enc_op_i)) begin
              next_s  = S_WRITE;
              latch_s = 1'b1;
            end else begin
              drop_s = 1'b1;
            end
          end else begin
            next_s = S_ACCEPT;
          end
        end
        S_WRITE: begin
          if (imem_ack_i) begin
            step_s = 1'b1;
            if (count_r == LAST) begin
              next_s = S_FULL;
              done_s = 1'b1;
            end else begin
              next_s = S_ACCEPT;
            end
          end else begin
            next_s = S_WRITE;
          end
        end
        S_FULL:  next_s = S_FULL;
        default: next_s = S_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Datapath and handshake outputs, registered from the decoded next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_r   <= 1'b0;
      wr_en_r   <= 1'b0;
      full_r    <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
      addr_r    <= BASE;
      count_r   <= {CNT_W{1'b0}};
      wr_data_r <= 32'h0000_0000;
    end else begin
      ready_r <= (next_s == S_ACCEPT);
      wr_en_r <= (next_s == S_WRITE);
      full_r  <= (next_s == S_FULL);
      done_r  <= done_s;
      if (latch_s) begin
        wr_data_r <= encode(enc_fmt_i, enc_op_i, enc_funct_i, enc_rs_i, enc_rt_i,
                            enc_rd_i, enc_shamt_i, enc_imm_i, enc_target_i);
      end
      if (reinit_s) begin
        addr_r  <= BASE;
        count_r <= {CNT_W{1'b0}};
        err_r   <= 1'b0;
      end else begin
        if (step_s) begin
          addr_r  <= addr_r + ADDR_W'(4);
          count_r <= count_r + CNT_W'(1);
        end
        if (drop_s) begin
          err_r <= 1'b1;
        end
      end
    end
  end

  assign enc_ready_o    = ready_r;
  assign imem_wr_en_o   = wr_en_r;
  assign imem_addr_o    = addr_r;
  assign imem_wr_data_o = wr_data_r;
  assign count_o        = count_r;
  assign full_o         = full_r;
  assign done_o         = done_r;
  assign err_o          = err_r;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader (DEPTH=4) with hand-computed instruction words.
module tb_instr_encoder_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i, stop_i, enc_valid_i, enc_ready_o;
  logic [1:0]  enc_fmt_i;
  logic [5:0]  enc_op_i, enc_funct_i;
  logic [4:0]  enc_rs_i, enc_rt_i, enc_rd_i, enc_shamt_i;
  logic [15:0] enc_imm_i;
  logic [25:0] enc_target_i;
  logic        imem_wr_en_o;
  logic [11:0] imem_addr_o;
  logic [31:0] imem_wr_data_o;
  logic        imem_ack_i;
  logic [2:0]  count_o;
  logic        full_o, done_o, err_o;

  int vectors = 0;
  int miscompares = 0;

  instr_encoder_loader #(.ADDR_W(12), .BASE_ADDR(0), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .stop_i(stop_i),
    .enc_valid_i(enc_valid_i), .enc_ready_o(enc_ready_o), .enc_fmt_i(enc_fmt_i),
    .enc_op_i(enc_op_i), .enc_funct_i(enc_funct_i), .enc_rs_i(enc_rs_i),
    .enc_rt_i(enc_rt_i), .enc_rd_i(enc_rd_i), .enc_shamt_i(enc_shamt_i),
    .enc_imm_i(enc_imm_i), .enc_target_i(enc_target_i), .imem_wr_en_o(imem_wr_en_o),
    .imem_addr_o(imem_addr_o), .imem_wr_data_o(imem_wr_data_o), .imem_ack_i(imem_ack_i),
    .count_o(count_o), .full_o(full_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic send(input string tag, input logic [1:0] fmt, input logic [5:0] op,
                      input logic [5:0] funct, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] shamt, input logic [15:0] imm,
                      input logic [25:0] target);
    int n = 0;
    enc_fmt_i = fmt; enc_op_i = op; enc_funct_i = funct; enc_rs_i = rs; enc_rt_i = rt;
    enc_rd_i = rd; enc_shamt_i = shamt; enc_imm_i = imm; enc_target_i = target;
    enc_valid_i = 1'b1;
    while (!enc_ready_o && n < 20) begin
      tick();
      n++;
    end
    if (!enc_ready_o) check_val({tag, "_ready_timeout"}, 32'(enc_ready_o), 32'd1);
    tick();
    enc_valid_i = 1'b0;
  endtask

  task automatic do_write(input string tag, input int dly, input logic [11:0] exp_addr,
                          input logic [31:0] exp_data);
    int n = 0;
    while (!imem_wr_en_o && n < 20) begin
      tick();
      n++;
    end
    check_val({tag, "_wren"}, 32'(imem_wr_en_o), 32'd1);
    check_val({tag, "_addr"}, 32'(imem_addr_o), 32'(exp_addr));
    check_val({tag, "_data"}, imem_wr_data_o, exp_data);
    for (int i = 0; i < dly; i++) begin
      tick();
      check_val({tag, "_hold_wren"}, 32'(imem_wr_en_o), 32'd1);
      check_val({tag, "_hold_data"}, imem_wr_data_o, exp_data);
      check_val({tag, "_hold_ready"}, 32'(enc_ready_o), 32'd0);
    end
    imem_ack_i = 1'b1;
    tick();
    imem_ack_i = 1'b0;
  endtask

  logic [31:0] fill_words [4] = '{32'h0000_0820, 32'h0000_1020, 32'h0000_1820, 32'h0000_2020};

  initial begin
    rst_n = 1'b0; start_i = 1'b0; stop_i = 1'b0; enc_valid_i = 1'b0; imem_ack_i = 1'b0;
    enc_fmt_i = 2'd0; enc_op_i = 6'h00; enc_funct_i = 6'h00; enc_rs_i = 5'd0; enc_rt_i = 5'd0;
    enc_rd_i = 5'd0; enc_shamt_i = 5'd0; enc_imm_i = 16'h0000; enc_target_i = 26'h0;
    tick();
    tick();
    check_val("rst_ready", 32'(enc_ready_o), 32'd0);
    check_val("rst_wren", 32'(imem_wr_en_o), 32'd0);
    check_val("rst_addr", 32'(imem_addr_o), 32'd0);
    check_val("rst_count", 32'(count_o), 32'd0);
    check_val("rst_flags", {29'd0, full_o, done_o, err_o}, 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: R-type ADD
    pulse_start();
    check_val("t1_ready", 32'(enc_ready_o), 32'd1);
    send("t1", 2'd0, 6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0000, 26'h0);
    do_write("t1", 0, 12'h000, 32'h0022_1820);
    check_val("t1_count", 32'(count_o), 32'd1);
    check_val("t1_addr_next", 32'(imem_addr_o), 32'h004);

    // 2: ADDI then LW
    pulse_start();
    send("t2a", 2'd1, 6'h08, 6'h00, 5'd0, 5'd8, 5'd0, 5'd0, 16'h0005, 26'h0);
    do_write("t2a", 0, 12'h000, 32'h2008_0005);
    send("t2b", 2'd1, 6'h23, 6'h00, 5'd29, 5'd9, 5'd0, 5'd0, 16'h0004, 26'h0);
    do_write("t2b", 0, 12'h004, 32'h8FA9_0004);
    check_val("t2_count", 32'(count_o), 32'd2);

    // 3: J with delayed ack
    pulse_start();
    send("t3", 2'd2, 6'h02, 6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0000, 26'h010_0000);
    do_write("t3", 3, 12'h000, 32'h0810_0000);
    check_val("t3_count", 32'(count_o), 32'd1);
    check_val("t3_ready_after", 32'(enc_ready_o), 32'd1);

    // 4: illegal requests are consumed and dropped
    pulse_start();
    send("t4a", 2'd3, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0000, 26'h0);
    check_val("t4a_err", 32'(err_o), 32'd1);
    check_val("t4a_wren", 32'(imem_wr_en_o), 32'd0);
    send("t4b", 2'd2, 6'h08, 6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0000, 26'h0);
    send("t4c", 2'd1, 6'h02, 6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0001, 26'h0);
    check_val("t4_count", 32'(count_o), 32'd0);
    check_val("t4_wren", 32'(imem_wr_en_o), 32'd0);
    check_val("t4_ready", 32'(enc_ready_o), 32'd1);
    send("t4d", 2'd0, 6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0000, 26'h0);
    do_write("t4d", 0, 12'h000, 32'h0022_1820);
    check_val("t4_err_sticky", 32'(err_o), 32'd1);

    // 5: fill to DEPTH
    pulse_start();
    check_val("t5_err_cleared", 32'(err_o), 32'd0);
    for (int i = 0; i < 4; i++) begin
      send("t5", 2'd0, 6'h00, 6'h20, 5'd0, 5'd0, 5'(i + 1), 5'd0, 16'h0000, 26'h0);
      do_write("t5", 0, 12'(i * 4), fill_words[i]);
      if (i < 3) check_val("t5_no_done", 32'(done_o), 32'd0);
    end
    check_val("t5_full", 32'(full_o), 32'd1);
    check_val("t5_done", 32'(done_o), 32'd1);
    check_val("t5_count", 32'(count_o), 32'd4);
    enc_valid_i = 1'b1;
    tick();
    check_val("t5_done_pulse", 32'(done_o), 32'd0);
    for (int i = 0; i < 3; i++) begin
      check_val("t5_no_ready", 32'(enc_ready_o), 32'd0);
      check_val("t5_no_wr", 32'(imem_wr_en_o), 32'd0);
      tick();
    end
    enc_valid_i = 1'b0;
    check_val("t5_full_hold", 32'(full_o), 32'd1);
    check_val("t5_addr_hold", 32'(imem_addr_o), 32'h010);

    // 6: start aborts a write, stop ignored in WRITE, async reset, stop in ACCEPT
    pulse_start();
    check_val("t6_full_clear", 32'(full_o), 32'd0);
    send("t6a", 2'd1, 6'h08, 6'h00, 5'd0, 5'd8, 5'd0, 5'd0, 16'h0005, 26'h0);
    do_write("t6a", 0, 12'h000, 32'h2008_0005);
    send("t6b", 2'd1, 6'h08, 6'h00, 5'd0, 5'd8, 5'd0, 5'd0, 16'h0006, 26'h0);
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    check_val("t6_stop_ignored", 32'(imem_wr_en_o), 32'd1);
    check_val("t6_stop_no_done", 32'(done_o), 32'd0);
    pulse_start();
    check_val("t6_abort_wren", 32'(imem_wr_en_o), 32'd0);
    check_val("t6_abort_count", 32'(count_o), 32'd0);
    check_val("t6_abort_addr", 32'(imem_addr_o), 32'h000);
    send("t6c", 2'd1, 6'h08, 6'h00, 5'd0, 5'd8, 5'd0, 5'd0, 16'h0007, 26'h0);
    do_write("t6c", 0, 12'h000, 32'h2008_0007);
    send("t6d", 2'd2, 6'h03, 6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0000, 26'h000_0040);
    check_val("t6_pre_rst_wren", 32'(imem_wr_en_o), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("t6_rst_wren", 32'(imem_wr_en_o), 32'd0);
    check_val("t6_rst_count", 32'(count_o), 32'd0);
    check_val("t6_rst_addr", 32'(imem_addr_o), 32'h000);
    tick();
    rst_n = 1'b1;
    tick();
    pulse_start();
    send("t6e", 2'd0, 6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0000, 26'h0);
    do_write("t6e", 0, 12'h000, 32'h0022_1820);
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    check_val("t6_stop_done", 32'(done_o), 32'd1);
    check_val("t6_stop_ready", 32'(enc_ready_o), 32'd0);
    tick();
    check_val("t6_done_pulse", 32'(done_o), 32'd0);
    check_val("t6_count_hold", 32'(count_o), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
